// File: rtl/uart_txrx_param_if.sv
// Bus bundle for the uart_txrx_param transceiver: TX request/status and RX word/status.
// The slave modport is the transceiver side; master is the user/link side.
interface uart_txrx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_frame_err;
    logic                 rx_parity_err;

    modport master (
        output tx_start, tx_data, rx,
        input  tx, tx_busy, tx_done, rx_data, rx_done, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  tx_start, tx_data, rx,
        output tx, tx_busy, tx_done, rx_data, rx_done, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_txrx_param.sv
// Parametrised full-duplex UART: independent TX/RX FSMs, mid-bit RX sampling, framing/parity flags.
// Optional parity bit is enabled by defining UART_PARITY_EN.
module uart_txrx_param #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    uart_txrx_param_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_txrx_param: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    // TX: shift the latched word out LSB first; tx changes only on bit boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
            bus.tx      <= 1'b1;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (bus.tx_start) begin
                        tx_shift    <= bus.tx_data;
`ifdef UART_PARITY_EN
                        tx_par      <= (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
                        tx_cnt      <= '0;
                        bus.tx      <= 1'b0;
                        bus.tx_busy <= 1'b1;
                        tx_state    <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        bus.tx   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            bus.tx   <= tx_par;
                            tx_state <= S_PARITY;
`else
                            bus.tx   <= 1'b1;
                            tx_idx   <= '0;
                            tx_state <= S_STOP;
`endif
                        end else begin
                            bus.tx   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_idx   <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        bus.tx   <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == STOP_LAST) begin
                            bus.tx_busy <= 1'b0;
                            bus.tx_done <= 1'b1;
                            tx_state    <= S_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    bus.tx      <= 1'b1;
                    bus.tx_busy <= 1'b0;
                    tx_state    <= S_IDLE;
                end
            endcase
        end
    end

    // RX synchroniser; third flop holds the previous synced value for edge detection
    logic rx_s1, rx_s2, rx_s3;
    logic rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= bus.rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;

    state_t               rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
`ifdef UART_PARITY_EN
    logic                 rx_par;
`else
    assign bus.rx_parity_err = 1'b0;
`endif

    // RX: half-bit offset after the start edge, then one sample per bit period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state         <= S_IDLE;
            rx_cnt           <= '0;
            rx_idx           <= '0;
            rx_shift         <= '0;
            bus.rx_data      <= '0;
            bus.rx_done      <= 1'b0;
            bus.rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par            <= 1'b0;
            bus.rx_parity_err <= 1'b0;
`endif
        end else begin
            bus.rx_done <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_s2;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Only the first stop bit is sampled; returning here allows back-to-back frames
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt           <= '0;
                        bus.rx_data      <= rx_shift;
                        bus.rx_frame_err <= ~rx_s2;
`ifdef UART_PARITY_EN
                        bus.rx_parity_err <= (^rx_shift) ^ rx_par ^ 1'(PARITY_ODD);
`endif
                        bus.rx_done      <= 1'b1;
                        rx_state         <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_txrx_param.sv
// Directed self-checking bench for uart_txrx_param (default parameters, optional UART_PARITY_EN).
module tb_uart_txrx_param;
    localparam int C = 16;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (1 + 8 + P + 1) * C;

    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic rx_drv;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] rxq[$];
    logic [1:0] errq[$];
    int         tx_done_cnt = 0;

    always #5 clk = ~clk;

    uart_txrx_param_if #(.DATA_BITS(8)) bus ();

    assign bus.rx = loop_en ? bus.tx : rx_drv;

    uart_txrx_param #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Record every received word and every TX completion
    always @(negedge clk) begin
        if (bus.rx_done) begin
            rxq.push_back(bus.rx_data);
            errq.push_back({bus.rx_frame_err, bus.rx_parity_err});
        end
        if (bus.tx_done) tx_done_cnt++;
    end

    task automatic clear_log();
        rxq.delete();
        errq.delete();
        tx_done_cnt = 0;
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic par, input logic stop);
        rx_drv = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = par;
        repeat (C) @(negedge clk);
`else
        if (par) rx_drv = 1'b0;
`endif
        rx_drv = stop;
        repeat (C) @(negedge clk);
        rx_drv = 1'b1;
        repeat (C) @(negedge clk);
    endtask

    task automatic check_one_rx(input string name, input logic [7:0] exp_d, input logic [1:0] exp_err);
        n_tests++;
        if (rxq.size() !== 1) begin
            n_fail++;
            $display("FAIL %s rx count: got %0d expected 1", name, rxq.size());
        end else begin
            n_tests++;
            if (rxq[0] !== exp_d) begin
                n_fail++;
                $display("FAIL %s rx_data: got %h expected %h", name, rxq[0], exp_d);
            end
            n_tests++;
            if (errq[0] !== exp_err) begin
                n_fail++;
                $display("FAIL %s {frame,parity}: got %b expected %b", name, errq[0], exp_err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; loop_en = 1'b0; rx_drv = 1'b1;
        bus.tx_start = 1'b0; bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset tx/busy/done: got %b expected 100", {bus.tx, bus.tx_busy, bus.tx_done});
        end
        n_tests++;
        if ({bus.rx_data, bus.rx_done, bus.rx_frame_err, bus.rx_parity_err} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset rx outputs: got %h expected 000",
                     {bus.rx_data, bus.rx_done, bus.rx_frame_err, bus.rx_parity_err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_single();
        int got = -1;
        loop_en = 1'b1;
        clear_log();
        bus.tx_data = 8'hA5; bus.tx_start = 1'b1;
        for (int k = 1; k <= F + 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.tx_start = 1'b0;
                n_tests++;
                if ({bus.tx, bus.tx_busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL single start bit tx/busy: got %b expected 01", {bus.tx, bus.tx_busy});
                end
            end
            if (bus.tx_done) begin got = k; break; end
        end
        n_tests++;
        if (got != F + 1) begin
            n_fail++;
            $display("FAIL single tx_done latency: got %0d expected %0d", got, F + 1);
        end
        n_tests++;
        if (bus.tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single busy at done: got %b expected 0", bus.tx_busy);
        end
        repeat (20) @(negedge clk);
        check_one_rx("single", 8'hA5, 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[10] = '{8'd10, 8'd200, 8'd37, 8'd128, 8'd99, 8'd15, 8'd171, 8'd64, 8'd142, 8'd55};
        int idx = 0;
        int idle_cnt = 0;
        int last_done = -1;
        loop_en = 1'b1;
        clear_log();
        bus.tx_data = words[0]; bus.tx_start = 1'b1;
        for (int k = 1; k <= 10 * (F + 1) + 100; k++) begin
            @(negedge clk);
            if (!bus.tx_busy) idle_cnt++;
            if (bus.tx_done) begin
                idx++;
                last_done = k;
                if (idx < 10) bus.tx_data = words[idx];
                else begin bus.tx_start = 1'b0; break; end
            end
        end
        n_tests++;
        if (last_done != 10 * (F + 1)) begin
            n_fail++;
            $display("FAIL b2b last tx_done cycle: got %0d expected %0d", last_done, 10 * (F + 1));
        end
        n_tests++;
        if (idle_cnt != 10) begin
            n_fail++;
            $display("FAIL b2b non-busy cycles: got %0d expected 10", idle_cnt);
        end
        repeat (30) @(negedge clk);
        n_tests++;
        if (tx_done_cnt != 10 || rxq.size() != 10) begin
            n_fail++;
            $display("FAIL b2b pulse counts: tx_done %0d rx_done %0d expected 10/10", tx_done_cnt, rxq.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_tests++;
                if (rxq[i] !== words[i] || errq[i] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL b2b word %0d: got %h err %b expected %h err 00", i, rxq[i], errq[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        loop_en = 1'b0; rx_drv = 1'b1;
        repeat (5) @(negedge clk);
        clear_log();
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * C) @(negedge clk);
        n_tests++;
        if (rxq.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch rx_done count: got %0d expected 0", rxq.size());
        end
        clear_log();
        drive_rx_frame(8'h96, 1'b0, 1'b1);
        check_one_rx("after_glitch", 8'h96, 2'b00);
    endtask

    task automatic test_frame_err();
        loop_en = 1'b0; rx_drv = 1'b1;
        clear_log();
        drive_rx_frame(8'h3C, 1'b0, 1'b0);
        check_one_rx("frame_err", 8'h3C, 2'b10);
        n_tests++;
        if (bus.rx_frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_err hold: got %b expected 1", bus.rx_frame_err);
        end
        clear_log();
        drive_rx_frame(8'h5A, 1'b0, 1'b1);
        check_one_rx("frame_ok", 8'h5A, 2'b00);
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        loop_en = 1'b0; rx_drv = 1'b1;
        clear_log();
        drive_rx_frame(8'h07, 1'b0, 1'b1);
        check_one_rx("parity_bad", 8'h07, 2'b01);
        clear_log();
        drive_rx_frame(8'h07, 1'b1, 1'b1);
        check_one_rx("parity_good", 8'h07, 2'b00);
    endtask
`endif

    task automatic test_reset_mid_frame();
        loop_en = 1'b1;
        clear_log();
        bus.tx_data = 8'h81; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (5 * C + 4) @(negedge clk);
        n_tests++;
        if ({bus.tx, bus.tx_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL midframe data bit 4: got %b expected 01", {bus.tx, bus.tx_busy});
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.tx, bus.tx_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL midframe async reset tx/busy: got %b expected 10", {bus.tx, bus.tx_busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * F) @(negedge clk);
        n_tests++;
        if (tx_done_cnt != 0 || rxq.size() != 0) begin
            n_fail++;
            $display("FAIL midframe aborted pulses: tx_done %0d rx_done %0d expected 0/0", tx_done_cnt, rxq.size());
        end
        bus.tx_data = 8'h81; bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (F + 20) @(negedge clk);
        n_tests++;
        if (tx_done_cnt != 1) begin
            n_fail++;
            $display("FAIL post-reset tx_done count: got %0d expected 1", tx_done_cnt);
        end
        check_one_rx("post_reset", 8'h81, 2'b00);
    endtask

    initial begin
        test_reset();
        test_loopback_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_txrx_param.md
# uart_txrx_param

Parametrised full-duplex UART transceiver for the serial link path. It has independent TX and RX state machines that share one clock. Data width, bit period and stop-bit count are set by parameters, and the parity bit is optional. The receiver adds start-bit glitch rejection, mid-bit sampling, and framing/parity error reporting. It is a drop-in TX/RX endpoint; a loopback of `tx` to `rx` must return every transmitted word unchanged.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be even and ≥ 4.
- `DATA_BITS`, 8: payload width; legal range 5..9.
- `STOP_BITS`, 1: transmitted stop bits; 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Only used when `UART_PARITY_EN` is defined.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_start`  in  1  request to send `tx_data`.
- `tx_data`  in  DATA_BITS  word to transmit.
- `tx`  out  1  serial output, idle high.
- `tx_busy`  out  1  high while a TX frame is in progress.
- `tx_done`  out  1  one-cycle pulse at the end of a TX frame.
- `rx`  in  1  serial input; asynchronous to `clk`.
- `rx_data`  out  DATA_BITS  last received word; holds its value until the next `rx_done`.
- `rx_done`  out  1  one-cycle pulse when a frame is received.
- `rx_frame_err`  out  1  valid with `rx_done`; set when the stop bit sampled 0.
- `rx_parity_err`  out  1  valid with `rx_done`; set on parity mismatch.

## Operation
- **Reset values:** `tx`=1, `tx_busy`=0, `tx_done`=0, `rx_data`=0, `rx_done`=0, both error outputs 0. The RX synchroniser flops reset to 1, so reset never produces a false start.
- **TX FSM:** IDLE → START → DATA → PARITY (only if enabled) → STOP → IDLE.
  - In IDLE, `tx_start`=1 latches `tx_data` and moves to START. `tx_start` is ignored while `tx_busy`=1.
  - Each state holds `tx` for exactly CLKS_PER_BIT cycles.
  - START drives 0. DATA sends the word LSB first. STOP drives 1 for STOP_BITS bit periods.
- **RX path:** `rx` passes through a 2-flop synchroniser. Every RX decision below uses the synchronised value.
- **RX FSM:** IDLE → START → DATA → PARITY (only if enabled) → STOP → IDLE.
  - IDLE waits for a synchronised 1→0 edge.
  - START counts CLKS_PER_BIT/2 cycles and then re-samples. If the line is high, the start is false: return to IDLE with no pulse.
  - After that, each bit is sampled once, every CLKS_PER_BIT cycles (mid-bit). Data is shifted in LSB first.
  - STOP samples only the first stop bit. On that sample: load `rx_data`, set `rx_frame_err` = !stop, set `rx_parity_err`, pulse `rx_done`, and go to IDLE.
  - Returning at mid-stop allows back-to-back frames and tolerates a stop bit of 1 or 2 bit periods from the sender.
- **Error behaviour:** `rx_data` is updated even when an error flag is set. The error flags hold their value until the next `rx_done`.
- **Independence:** TX and RX run fully independently. Simultaneous TX and RX activity is required to work.
- **Reset during a frame:** asserting `rst` mid-frame aborts both FSMs immediately. No `tx_done` or `rx_done` pulse is produced for the aborted frame.

## Timing
- **TX start:** `tx_start` sampled at edge N → `tx`=0 and `tx_busy`=1 from edge N+1.
- **Frame length:** F = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 with parity and 0 without. Default F = 160.
- **TX completion:** `tx_done`=1 and `tx_busy`=0 in cycle N+1+F.
- **Back-to-back TX:** `tx_start` asserted in the `tx_done` cycle is accepted. The next start bit begins in the following cycle, giving zero idle bits between frames.
- **RX latency:** `rx_done` asserts CLKS_PER_BIT/2 + 3 cycles (±1) after the falling edge of the stop bit's leading boundary on `rx`. This is 2 synchroniser cycles, plus the mid-bit offset, plus 1 register cycle.
- **Glitch rejection:** an `rx` low pulse shorter than CLKS_PER_BIT/2 − 2 cycles is rejected.
- **Output registering:** all outputs are registered. No combinational path from any input to any output.

## Configuration
- **`UART_PARITY_EN` defined:**
  - A parity bit follows the data bits on TX.
  - RX checks that bit against PARITY_ODD and reports the result on `rx_parity_err`.
  - Frame is one bit longer.
- **`UART_PARITY_EN` undefined:**
  - No PARITY state in either FSM.
  - `rx_parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.

## Test plan
- **Loopback, single word:** defaults, `tx`→`rx`, send 0xA5 → `tx_done` 161 cycles after `tx_start`; `rx_data`=0xA5 with `rx_done` pulse, both error flags 0.
- **Loopback, back-to-back stream:** hold `tx_start`=1 and send 10 random words in 10..200 → each word is received in order, no idle gap on `tx`, exactly 10 `tx_done` and 10 `rx_done` pulses.
- **Glitch rejection:** drive `rx` low for 3 cycles, then high → no `rx_done`; RX FSM returns to IDLE.
- **Framing error:** drive a frame of 0x3C with stop bit 0 → `rx_done`=1, `rx_frame_err`=1, `rx_data`=0x3C.
- **Parity error:** with `UART_PARITY_EN` and PARITY_ODD=0, send 0x07 with parity bit 0 → `rx_parity_err`=1. The same frame with parity bit 1 → `rx_parity_err`=0.
- **Reset mid-frame:** assert `rst` during data bit 4 of a TX frame → `tx`=1 and `tx_busy`=0 immediately, no `tx_done`. After release, a new 0x81 frame loops back correctly.
